// File: rtl/alu_iter_unit_pkg.sv
// rtl/alu_iter_unit_pkg.sv - op codes and FSM states shared by the iterative ALU
// Package alu_pkg:
//   alu_op_e : 4-bit operation code (13..15 are compares, only legal with ALU_CMP_EN)
//   state_e  : IDLE / BUSY / DONE control states
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_XOR = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_NOR = 4'd7,
        OP_SRL = 4'd8,
        OP_SLL = 4'd9,
        OP_SRA = 4'd10,
        OP_SLA = 4'd11,
        OP_EQ  = 4'd13,
        OP_LT  = 4'd14,
        OP_GT  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_div_iter.sv
// rtl/alu_div_iter.sv - unsigned restoring divider, one quotient bit per cycle
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              load dividend/divisor magnitudes and begin
//   dividend, divisor  unsigned magnitudes (WIDTH bits)
//   done               high during the cycle whose edge retires the last bit
//   quotient           quotient including the bit being produced this cycle
module alu_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             active;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // Dividend bits are shifted out of quo's top while quotient bits enter at the bottom.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        qbit     = ~diff[WIDTH];
        rem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], qbit};
    end

    assign done     = active && (cnt == CW'(WIDTH - 1));
    assign quotient = quo_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            rem    <= '0;
            quo    <= dividend;
            dvs    <= divisor;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1))
                active <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - multi-cycle ALU with iterative MUL/DIV and valid/ready handshakes
// Optional feature macro: ALU_CMP_EN (ops 13 EQ, 14 LT, 15 GT signed compares)
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE)
//   a, b, op             signed operands and alu_op_e code, captured at accept
//   out_valid / out_ready result handshake (result/err held while out_ready low)
//   result, err          result and error flag (div-by-zero, illegal op)
//   busy                 state != IDLE
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_e           state;
    alu_op_e          op_in;
    alu_op_e          op_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             neg_q;
    logic             dz;

    logic [WIDTH-1:0] sc_res;
    logic             sc_err;
    logic [CW-1:0]    shamt;
    logic signed [WIDTH-1:0] sa;

    logic             div_start;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_done;
    logic [WIDTH-1:0] div_q;
    logic             busy_last;

    assign op_in = alu_op_e'(op);
    assign shamt = b[CW-1:0];
    assign sa    = a;

    // Single-cycle ops evaluate directly on the accepted inputs.
    always_comb begin
        sc_res = '0;
        sc_err = 1'b0;
        case (op_in)
            OP_ADD:         sc_res = a + b;
            OP_SUB:         sc_res = a - b;
            OP_XOR:         sc_res = a ^ b;
            OP_AND:         sc_res = a & b;
            OP_OR:          sc_res = a | b;
            OP_NOR:         sc_res = ~(a | b);
            OP_SRL:         sc_res = a >> shamt;
            OP_SLL, OP_SLA: sc_res = a << shamt;
            OP_SRA:         sc_res = sa >>> shamt;
            OP_MUL, OP_DIV: sc_res = '0;
`ifdef ALU_CMP_EN
            OP_EQ:          sc_res = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_LT:          sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_GT:          sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
`endif
            default:        sc_err = 1'b1;
        endcase
    end

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // The divider works on magnitudes; the sign is reapplied when entering DONE.
    assign a_mag     = a[WIDTH-1] ? -a : a;
    assign b_mag     = b[WIDTH-1] ? -b : b;
    assign div_start = (state == IDLE) && in_valid && (op_in == OP_DIV);

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (a_mag),
        .divisor  (b_mag),
        .done     (div_done),
        .quotient (div_q)
    );

    assign busy_last = (op_r == OP_DIV) ? div_done : (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_r      <= OP_ADD;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            neg_q     <= 1'b0;
            dz        <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r     <= op_in;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (op_in == OP_MUL || op_in == OP_DIV) begin
                            state  <= BUSY;
                            cnt    <= '0;
                            mcand  <= a;
                            mplier <= b;
                            acc    <= '0;
                            neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                            dz     <= (b == '0);
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= sc_res;
                            err       <= sc_err;
                        end
                    end
                end
                BUSY: begin
                    cnt    <= cnt + 1'b1;
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (busy_last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        if (op_r == OP_MUL) begin
                            result <= acc_next;
                            err    <= 1'b0;
                        end else if (dz) begin
                            result <= '1;
                            err    <= 1'b1;
                        end else begin
                            result <= neg_q ? -div_q : div_q;
                            err    <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter_unit.sv
// tb/tb_alu_iter_unit.sv - scoreboard bench for alu_iter_unit
module tb_alu_iter_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         in_ready;
    logic         out_valid;
    logic         err;
    logic         busy;
    logic [W-1:0] result;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    alu_iter_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic e);
        r = '0;
        e = 1'b0;
        case (o)
            4'd0:        r = x + y;
            4'd1:        r = x - y;
            4'd2:        r = x * y;
            4'd3: begin
                if (y == '0) begin
                    r = '1;
                    e = 1'b1;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    r = x;
                end else begin
                    r = $signed(x) / $signed(y);
                end
            end
            4'd4:        r = x ^ y;
            4'd5:        r = x & y;
            4'd6:        r = x | y;
            4'd7:        r = ~(x | y);
            4'd8:        r = x >> y[4:0];
            4'd9, 4'd11: r = x << y[4:0];
            4'd10:       r = $signed(x) >>> y[4:0];
`ifdef ALU_CMP_EN
            4'd13:       r = {31'b0, (x == y)};
            4'd14:       r = {31'b0, ($signed(x) < $signed(y))};
            4'd15:       r = {31'b0, ($signed(x) > $signed(y))};
`endif
            default:     e = 1'b1;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        exp_t e;
        exp_t got;
        int   cyc;
        bit   ir_bad;
        model(o, x, y, e.res, e.err);
        e.lat = (o == 4'd2 || o == 4'd3) ? W + 1 : 1;
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 4'($urandom);
        cyc = 1;
        ir_bad = 1'b0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            if (in_ready !== 1'b0) ir_bad = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (in_ready !== 1'b0) ir_bad = 1'b1;
        got = sb.pop_front();
        total++;
        if (out_valid !== 1'b1) $display("FAIL %s timeout out_valid=%b required 1", tag, out_valid);
        else passed++;
        total++;
        if (result !== got.res) $display("FAIL %s result got %h required %h", tag, result, got.res);
        else passed++;
        total++;
        if (err !== got.err) $display("FAIL %s err got %b required %b", tag, err, got.err);
        else passed++;
        total++;
        if (cyc !== got.lat) $display("FAIL %s latency got %0d required %0d", tag, cyc, got.lat);
        else passed++;
        total++;
        if (ir_bad) $display("FAIL %s in_ready high while op in flight, required 0", tag);
        else passed++;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s handshake out_valid=%b in_ready=%b required 0/1", tag, out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset in_ready got %b required 1", in_ready);
        else passed++;
        total++;
        if (out_valid !== 1'b0) $display("FAIL reset out_valid got %b required 0", out_valid);
        else passed++;
        total++;
        if (result !== '0) $display("FAIL reset result got %h required 0", result);
        else passed++;
        total++;
        if (err !== 1'b0 || busy !== 1'b0) $display("FAIL reset err/busy got %b/%b required 0/0", err, busy);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        run_op(4'd0, 32'd5, 32'd7, "add");
        run_op(4'd1, 32'd3, 32'd5, "sub");
        run_op(4'd7, 32'h0F0F_0000, 32'h0000_00FF, "nor");
    endtask

    task automatic test_mul();
        run_op(4'd2, 32'hFFFF_FFFD, 32'd7, "mul_neg");
        run_op(4'd2, 32'h1234_5678, 32'h9ABC_DEF1, "mul_wrap");
    endtask

    task automatic test_div();
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_min");
        run_op(4'd3, 32'd9, 32'd0, "div_zero");
        run_op(4'd3, 32'd100, 32'hFFFF_FFF9, "div_pos_neg");
    endtask

    task automatic test_shift();
        run_op(4'd10, 32'h8000_0000, 32'd4, "sra");
        run_op(4'd8, 32'h8000_0000, 32'd4, "srl");
        run_op(4'd9, 32'd1, 32'd33, "sll_mod");
        run_op(4'd11, 32'd3, 32'd31, "sla");
    endtask

    task automatic test_illegal_cmp();
        run_op(4'd12, 32'd1, 32'd2, "illegal12");
        run_op(4'd13, 32'd42, 32'd42, "cmp_eq");
        run_op(4'd14, 32'hFFFF_FFFB, 32'd3, "cmp_lt");
        run_op(4'd15, 32'hFFFF_FFFB, 32'd3, "cmp_gt");
    endtask

    task automatic test_backpressure();
        exp_t e;
        exp_t got;
        model(4'd0, 32'd100, 32'd23, e.res, e.err);
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'd0;
        a = 32'd100;
        b = 32'd23;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        got = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0];
            op = 4'd1;
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || result !== got.res || in_ready !== 1'b0 || err !== got.err)
                $display("FAIL stall%0d ov=%b res=%h ir=%b err=%b required 1/%h/0/%b",
                         i, out_valid, result, in_ready, err, got.res, got.err);
            else passed++;
        end
        model(4'd0, 32'd1, 32'd1, e.res, e.err);
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'd0;
        a = 32'd1;
        b = 32'd1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL no_accept_in_handshake ov=%b ir=%b required 0/1", out_valid, in_ready);
        else passed++;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        got = sb.pop_front();
        total++;
        if (out_valid !== 1'b1 || result !== got.res)
            $display("FAIL next_accept ov=%b res=%h required 1/%h", out_valid, result, got.res);
        else passed++;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_div();
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'd3;
        a = 32'd1000;
        b = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || result !== '0)
            $display("FAIL rst_mid_div ov=%b res=%h required 0/0", out_valid, result);
        else passed++;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL rst_mid_div ir=%b busy=%b required 1/0", in_ready, busy);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        run_op(4'd3, 32'd1000, 32'd7, "div_after_rst");
    endtask

    task automatic test_back_to_back();
        logic [3:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        for (int i = 0; i < 16; i++) begin
            o = 4'($urandom_range(0, 15));
            x = $urandom;
            y = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            run_op(o, x, y, $sformatf("rand%0d_op%0d", i, o));
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_shift();
        test_illegal_cmp();
        test_backpressure();
        test_reset_mid_div();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
